// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian
// bytes into 32-bit words and writes them from address 0 upward.
module imem_loader #(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PC_WIDTH-2:0] num_words,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                we,
  output logic [PC_WIDTH-1:0] waddr,
  output logic [31:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic [PC_WIDTH-2:0] word_count
);

  localparam int MEM_SIZE = 2 ** (PC_WIDTH - 2);
  localparam int CW = PC_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] target;
  logic [CW-1:0] clamped;
  logic [CW-1:0] next_count;
  logic [1:0]    lane;
  logic [23:0]   asm_q;
  logic          hs;

  assign hs = byte_valid & byte_ready;
  assign next_count = word_count + 1'b1;
  assign clamped = (num_words > CW'(MEM_SIZE)) ?
                   CW'(MEM_SIZE) : num_words;

  // asm_q only holds lanes 0..2; lane 3 goes straight into wdata so a
  // byte taken during the write cycle never disturbs the word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      lane       <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            target     <= clamped;
            word_count <= '0;
            lane       <= '0;
            if (clamped == '0) begin
              state <= DONE;
            end else begin
              state      <= LOAD;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            lane <= lane + 1'b1;
            if (lane == 2'd3) begin
              we         <= 1'b1;
              wdata      <= {byte_data, asm_q};
              waddr      <= {word_count[PC_WIDTH-3:0], 2'b00};
              word_count <= next_count;
              if (next_count == target) begin
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                state      <= DONE;
              end
            end else begin
              asm_q[{lane, 3'b000} +: 8] <= byte_data;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
